lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//  Sequences AGU memory commands onto a single-outstanding valid/ready memory bus.
//  Aligns and extends load data, and returns write-back data/error to the AGU
//  (memtop_wback_data / memtop_wback_err).
//  Sits between the AGU (execute stage) and the data-memory bus. Stalls the pipeline
//  through lsu_o_busy while an access is in flight.
// PARAMETERS
//  XLEN         32   datapath width; only 32 is supported (4 byte lanes)
//  TIMEOUT_CYC  255  cycles allowed in REQ+RSP before a bus-timeout error; 1..255
// PORTS
//  clk               in   1       core clock
//  rst               in   1       synchronous, active-high reset
//  agu_cmd_enable    in   1       command present this cycle
//  agu_cmd_read      in   1       load
//  agu_cmd_write     in   1       store
//  agu_cmd_usign     in   1       zero-extend load (else sign-extend)
//  agu_cmd_size      in   2       00 byte, 01 half, 10 word (11 illegal -> error)
//  agu_cmd_addr      in   XLEN    byte address
//  agu_cmd_wdata     in   XLEN    lane-replicated store data
//  agu_cmd_wmask     in   XLEN/8  store byte enables
//  agu_cmd_misalgn   in   1       misaligned access flag
//  lsu_o_busy        out  1       command not accepted / access in flight: stall
//  bus_cmd_valid     out  1       bus request valid
//  bus_cmd_ready     in   1       bus accepts request
//  bus_cmd_read      out  1       1 = read, 0 = write
//  bus_cmd_addr      out  XLEN    word-aligned address {addr[31:2],2'b00}
//  bus_cmd_wdata     out  XLEN    store data
//  bus_cmd_wmask     out  XLEN/8  byte enables (4'b0000 on reads)
//  bus_rsp_valid     in   1       response valid (bus always accepted, no rsp_ready)
//  bus_rsp_err       in   1       bus error
//  bus_rsp_rdata     in   XLEN    raw read word
//  memtop_wback_vld  out  1       one-cycle pulse: access complete
//  memtop_wback_err  out  1       error qualifier for memtop_wback_vld
//  memtop_wback_data out  XLEN    extended load data (0 for stores/errors)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0, including bus_cmd_valid, lsu_o_busy, memtop_*; timeout counter=0.
//  Accept: IDLE & agu_cmd_enable & (read^write). A command with read==write is ignored.
//    On accept, addr/size/usign/read/wdata/wmask and addr[1:0] are captured in registers.
//  Bus outputs come from registers only, never from agu_cmd_*.
//  lsu_o_busy = agu_cmd_enable & (state!=IDLE), or the accept cycle itself. The command
//    must be held until busy drops.
//  States:
//   IDLE -> ERR  : accept & (misalgn | size==11). No bus request is issued.
//   IDLE -> REQ  : accept otherwise. bus_cmd_valid=1 from the next cycle.
//   REQ  -> RSP  : bus_cmd_ready. Valid drops the cycle after the handshake; held stable until then.
//   RSP  -> DONE : bus_rsp_valid. Captures rdata and err.
//   REQ/RSP -> ERR : timeout counter reaches TIMEOUT_CYC. A late rsp is dropped,
//     and bus_cmd_valid is deasserted.
//   DONE/ERR -> IDLE : after one cycle. memtop_wback_vld=1 in that cycle.
//  memtop_wback_err=1 in ERR, or in DONE when rsp_err=1. In DONE, memtop_wback_data is:
//    load  : word >> (8*addr[1:0]); byte -> bits[7:0], half -> bits[15:0];
//            then zero-extend if usign, else sign-extend from bit 7/15.
//    store : 0.
//  Latency: a zero-wait bus gives accept@t, valid@t+1, rsp@t+2, wback_vld@t+3.
//  A response in the same cycle as ready (rsp_valid while in REQ) is illegal. The bus
//    guarantees that rsp comes >=1 cycle after the handshake.
//  Timeout counter: cleared on accept; increments each cycle in REQ/RSP; saturates.
//  rst mid-access: returns to IDLE and drops bus_cmd_valid. The in-flight response is
//    ignored.
// TESTING
//  1 LW addr=0x100, ready same cycle, rsp rdata=0xDEADBEEF next cycle
//    -> wback_vld at accept+3, data=0xDEADBEEF, err=0.
//  2 LB addr=0x103 usign=0, rdata=0x80FF1234 -> data=0xFFFFFF80;
//    LHU addr=0x102, same rdata -> data=0x000080FF.
//  3 SH addr=0x202 wmask=4'b1100 wdata=0xABCDABCD, ready stalled 3 cycles
//    -> valid/addr=0x200/wmask stable for 4 cycles; wback data=0, err=0.
//  4 LW addr=0x101 misalgn=1 -> no bus_cmd_valid; wback_vld 1 cycle after accept, err=1.
//  5 TIMEOUT_CYC=4, bus never responds -> err pulse after 4 cycles in REQ/RSP; a late
//    rsp is ignored; next LW completes normally.
//  6 rst asserted while in RSP -> busy=0 and bus_cmd_valid=0 next cycle; no wback_vld;
//    back-to-back loads after reset both complete.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: sequences AGU load/store commands onto a single-outstanding valid/ready bus
module lsu_ctrl #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              agu_cmd_enable,
  input  logic              agu_cmd_read,
  input  logic              agu_cmd_write,
  input  logic              agu_cmd_usign,
  input  logic [1:0]        agu_cmd_size,
  input  logic [XLEN-1:0]   agu_cmd_addr,
  input  logic [XLEN-1:0]   agu_cmd_wdata,
  input  logic [XLEN/8-1:0] agu_cmd_wmask,
  input  logic              agu_cmd_misalgn,
  output logic              lsu_o_busy,
  output logic              bus_cmd_valid,
  input  logic              bus_cmd_ready,
  output logic              bus_cmd_read,
  output logic [XLEN-1:0]   bus_cmd_addr,
  output logic [XLEN-1:0]   bus_cmd_wdata,
  output logic [XLEN/8-1:0] bus_cmd_wmask,
  input  logic              bus_rsp_valid,
  input  logic              bus_rsp_err,
  input  logic [XLEN-1:0]   bus_rsp_rdata,
  output logic              memtop_wback_vld,
  output logic              memtop_wback_err,
  output logic [XLEN-1:0]   memtop_wback_data
);
  typedef enum logic [2:0] {IDLE, REQ, RSP, DONE, ERR} state_t;
  state_t state, state_nxt;
  logic accept, bad, tmo, usign_q, read_q, err_q;
  logic [7:0] cnt;
  logic [1:0] size_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q, sh, ext;
  logic [XLEN/8-1:0] wmask_q;
  assign accept = (state == IDLE) && agu_cmd_enable && (agu_cmd_read ^ agu_cmd_write);
  assign bad    = agu_cmd_misalgn || (agu_cmd_size == 2'b11);
  assign tmo    = (int'(cnt) + 1) >= TIMEOUT_CYC;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? (bad ? ERR : REQ) : IDLE;
      REQ:     state_nxt = tmo ? ERR : (bus_cmd_ready ? RSP : REQ);
      RSP:     state_nxt = bus_rsp_valid ? DONE : (tmo ? ERR : RSP);
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      size_q  <= '0;
      usign_q <= 1'b0;
      read_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt     <= '0;
        addr_q  <= agu_cmd_addr;
        wdata_q <= agu_cmd_wdata;
        wmask_q <= agu_cmd_write ? agu_cmd_wmask : '0;
        size_q  <= agu_cmd_size;
        usign_q <= agu_cmd_usign;
        read_q  <= agu_cmd_read;
      end else if ((state == REQ || state == RSP) && cnt != 8'hFF) begin
        cnt <= cnt + 8'd1;
      end
      if (state == RSP && bus_rsp_valid) begin
        rdata_q <= bus_rsp_rdata;
        err_q   <= bus_rsp_err;
      end
    end
  end
  // shift the addressed lane down to bit 0, then extend to the access size
  assign sh  = rdata_q >> {addr_q[1:0], 3'b000};
  assign ext = (size_q == 2'b00) ? {{(XLEN-8){~usign_q & sh[7]}}, sh[7:0]} :
               (size_q == 2'b01) ? {{(XLEN-16){~usign_q & sh[15]}}, sh[15:0]} : sh;
  assign lsu_o_busy        = (agu_cmd_enable && state != IDLE) || accept;
  assign bus_cmd_valid     = state == REQ;
  assign bus_cmd_read      = read_q;
  assign bus_cmd_addr      = {addr_q[XLEN-1:2], 2'b00};
  assign bus_cmd_wdata     = wdata_q;
  assign bus_cmd_wmask     = wmask_q;
  assign memtop_wback_vld  = state == DONE || state == ERR;
  assign memtop_wback_err  = state == ERR || (state == DONE && err_q);
  assign memtop_wback_data = (state == DONE && read_q && !err_q) ? ext : '0;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: table-driven directed checks of lsu_ctrl plus timeout/reset sequences
module tb_lsu_ctrl;
  logic clk = 0, rst = 1;
  logic agu_cmd_enable = 0, agu_cmd_read = 0, agu_cmd_write = 0, agu_cmd_usign = 0, agu_cmd_misalgn = 0;
  logic [1:0] agu_cmd_size = 0;
  logic [31:0] agu_cmd_addr = 0, agu_cmd_wdata = 0, bus_rsp_rdata = 0;
  logic [3:0] agu_cmd_wmask = 0;
  logic bus_cmd_ready = 0, bus_rsp_valid = 0, bus_rsp_err = 0;
  logic busy, valid, rd, wb_vld, wb_err;
  logic [31:0] addr, wdata, wb_data;
  logic [3:0] wmask;
  logic t_busy, t_valid, t_rd, t_wb_vld, t_wb_err;
  logic [31:0] t_addr, t_wdata, t_wb_data;
  logic [3:0] t_wmask;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  lsu_ctrl dut (
    .clk(clk), .rst(rst), .agu_cmd_enable(agu_cmd_enable), .agu_cmd_read(agu_cmd_read),
    .agu_cmd_write(agu_cmd_write), .agu_cmd_usign(agu_cmd_usign), .agu_cmd_size(agu_cmd_size),
    .agu_cmd_addr(agu_cmd_addr), .agu_cmd_wdata(agu_cmd_wdata), .agu_cmd_wmask(agu_cmd_wmask),
    .agu_cmd_misalgn(agu_cmd_misalgn), .lsu_o_busy(busy), .bus_cmd_valid(valid),
    .bus_cmd_ready(bus_cmd_ready), .bus_cmd_read(rd), .bus_cmd_addr(addr), .bus_cmd_wdata(wdata),
    .bus_cmd_wmask(wmask), .bus_rsp_valid(bus_rsp_valid), .bus_rsp_err(bus_rsp_err),
    .bus_rsp_rdata(bus_rsp_rdata), .memtop_wback_vld(wb_vld), .memtop_wback_err(wb_err),
    .memtop_wback_data(wb_data)
  );
  lsu_ctrl #(.TIMEOUT_CYC(4)) dut_t (
    .clk(clk), .rst(rst), .agu_cmd_enable(agu_cmd_enable), .agu_cmd_read(agu_cmd_read),
    .agu_cmd_write(agu_cmd_write), .agu_cmd_usign(agu_cmd_usign), .agu_cmd_size(agu_cmd_size),
    .agu_cmd_addr(agu_cmd_addr), .agu_cmd_wdata(agu_cmd_wdata), .agu_cmd_wmask(agu_cmd_wmask),
    .agu_cmd_misalgn(agu_cmd_misalgn), .lsu_o_busy(t_busy), .bus_cmd_valid(t_valid),
    .bus_cmd_ready(bus_cmd_ready), .bus_cmd_read(t_rd), .bus_cmd_addr(t_addr), .bus_cmd_wdata(t_wdata),
    .bus_cmd_wmask(t_wmask), .bus_rsp_valid(bus_rsp_valid), .bus_rsp_err(bus_rsp_err),
    .bus_rsp_rdata(bus_rsp_rdata), .memtop_wback_vld(t_wb_vld), .memtop_wback_err(t_wb_err),
    .memtop_wback_data(t_wb_data)
  );
  typedef struct {
    logic rd, wr, us;
    logic [1:0] sz;
    logic [31:0] addr, wdata;
    logic [3:0] wmask;
    logic mis;
    logic [31:0] rdata;
    logic rerr;
    int stall, lat, nvalid;
    logic eerr;
    logic [31:0] edata;
  } vec_t;
  vec_t vt[12];
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic run(input int i);
    vec_t v;
    int nv;
    bit got, pend;
    v = vt[i];
    nv = 0;
    got = 0;
    pend = 0;
    agu_cmd_enable = 1; agu_cmd_read = v.rd; agu_cmd_write = v.wr; agu_cmd_usign = v.us;
    agu_cmd_size = v.sz; agu_cmd_addr = v.addr; agu_cmd_wdata = v.wdata; agu_cmd_wmask = v.wmask;
    agu_cmd_misalgn = v.mis; bus_rsp_rdata = v.rdata; bus_rsp_err = v.rerr;
    #1;
    chk($sformatf("v%0d_busy_accept", i), busy, 1);
    chk($sformatf("v%0d_valid_accept", i), valid, 0);
    for (int c = 1; c <= 20 && !got; c++) begin
      step;
      bus_rsp_valid = pend;
      pend = 0;
      bus_cmd_ready = 0;
      if (valid) begin
        nv++;
        chk($sformatf("v%0d_addr", i), addr, {v.addr[31:2], 2'b00});
        chk($sformatf("v%0d_read", i), rd, v.rd);
        chk($sformatf("v%0d_wmask", i), wmask, v.rd ? 4'b0000 : v.wmask);
        if (v.wr) chk($sformatf("v%0d_wdata", i), wdata, v.wdata);
        if (nv > v.stall) begin
          bus_cmd_ready = 1;
          pend = 1;
        end
      end
      #1;
      chk($sformatf("v%0d_busy", i), busy, 1);
      if (wb_vld) begin
        got = 1;
        chk($sformatf("v%0d_latency", i), c, v.lat);
        chk($sformatf("v%0d_err", i), wb_err, v.eerr);
        chk($sformatf("v%0d_data", i), wb_data, v.edata);
        chk($sformatf("v%0d_valid_cycles", i), nv, v.nvalid);
        agu_cmd_enable = 0;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL v%0d_wback_timeout: got no wback_vld expected one within 20 cycles", i);
      agu_cmd_enable = 0;
    end
    bus_cmd_ready = 0;
    bus_rsp_valid = 0;
    step;
    chk($sformatf("v%0d_wback_once", i), wb_vld, 0);
  endtask
  initial begin
    //          rd    wr    us    sz     addr          wdata         wmask    mis   rdata         rerr  st lat nv eerr  edata
    vt[0]  = '{1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0,        4'h0,    1'b0, 32'hDEAD_BEEF, 1'b0, 0, 3, 1, 1'b0, 32'hDEAD_BEEF};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0103, 32'h0,        4'h0,    1'b0, 32'h80FF_1234, 1'b0, 0, 3, 1, 1'b0, 32'hFFFF_FF80};
    vt[2]  = '{1'b1, 1'b0, 1'b1, 2'b01, 32'h0000_0102, 32'h0,        4'h0,    1'b0, 32'h80FF_1234, 1'b0, 0, 3, 1, 1'b0, 32'h0000_80FF};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_0102, 32'h0,        4'h0,    1'b0, 32'h80FF_1234, 1'b0, 0, 3, 1, 1'b0, 32'hFFFF_80FF};
    vt[4]  = '{1'b1, 1'b0, 1'b1, 2'b00, 32'h0000_0101, 32'h0,        4'h0,    1'b0, 32'h80FF_1234, 1'b0, 0, 3, 1, 1'b0, 32'h0000_0012};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 2'b01, 32'h0000_0202, 32'hABCD_ABCD, 4'b1100, 1'b0, 32'h1111_1111, 1'b0, 3, 6, 4, 1'b0, 32'h0};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0101, 32'h0,        4'h0,    1'b1, 32'h2222_2222, 1'b0, 0, 1, 0, 1'b1, 32'h0};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 2'b11, 32'h0000_0104, 32'h0,        4'h0,    1'b0, 32'h3333_3333, 1'b0, 0, 1, 0, 1'b1, 32'h0};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0108, 32'h0,        4'h0,    1'b0, 32'h1234_5678, 1'b1, 0, 3, 1, 1'b1, 32'h0};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 2'b10, 32'h0000_010C, 32'h55AA_55AA, 4'hF,    1'b0, 32'h4444_4444, 1'b0, 1, 4, 2, 1'b0, 32'h0};
    vt[10] = '{1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0400, 32'h0,        4'h0,    1'b0, 32'h1122_3344, 1'b0, 0, 3, 1, 1'b0, 32'h1122_3344};
    vt[11] = '{1'b1, 1'b0, 1'b1, 2'b00, 32'h0000_0403, 32'h0,        4'h0,    1'b0, 32'h1122_3344, 1'b0, 0, 3, 1, 1'b0, 32'h0000_0011};
    repeat (3) step;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_wback_vld", wb_vld, 0);
    chk("rst_wback_err", wb_err, 0);
    chk("rst_wback_data", wb_data, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wmask", wmask, 0);
    chk("rst_read", rd, 0);
    rst = 0;
    step;
    agu_cmd_enable = 1; agu_cmd_read = 1; agu_cmd_write = 1;
    #1;
    chk("ignored_busy", busy, 0);
    step;
    chk("ignored_valid", valid, 0);
    chk("ignored_wback", wb_vld, 0);
    agu_cmd_enable = 0; agu_cmd_write = 0;
    step;
    chk("ignored_valid2", valid, 0);
    for (int i = 0; i < 10; i++) run(i);
    agu_cmd_enable = 1; agu_cmd_read = 1; agu_cmd_write = 0; agu_cmd_misalgn = 0;
    agu_cmd_size = 2'b10; agu_cmd_addr = 32'h300; bus_rsp_err = 0;
    step;
    agu_cmd_enable = 0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("tmo_valid_c%0d", c), t_valid, 1);
      chk($sformatf("tmo_wback_c%0d", c), t_wb_vld, 0);
      step;
    end
    chk("tmo_wback_vld", t_wb_vld, 1);
    chk("tmo_wback_err", t_wb_err, 1);
    chk("tmo_wback_data", t_wb_data, 0);
    chk("tmo_valid_drop", t_valid, 0);
    step;
    bus_rsp_valid = 1; bus_rsp_rdata = 32'hCAFE_F00D;
    #1;
    chk("tmo_late_rsp_wback", t_wb_vld, 0);
    step;
    bus_rsp_valid = 0;
    chk("tmo_late_rsp_wback2", t_wb_vld, 0);
    chk("tmo_late_rsp_valid", t_valid, 0);
    agu_cmd_enable = 1; agu_cmd_addr = 32'h304;
    step;
    agu_cmd_enable = 0;
    chk("tmo_next_valid", t_valid, 1);
    chk("tmo_next_addr", t_addr, 32'h304);
    bus_cmd_ready = 1;
    step;
    bus_cmd_ready = 0;
    bus_rsp_valid = 1; bus_rsp_rdata = 32'h0BAD_F00D;
    step;
    bus_rsp_valid = 0;
    chk("tmo_next_wback_vld", t_wb_vld, 1);
    chk("tmo_next_wback_err", t_wb_err, 0);
    chk("tmo_next_wback_data", t_wb_data, 32'h0BAD_F00D);
    rst = 1;
    repeat (2) step;
    rst = 0;
    step;
    agu_cmd_enable = 1; agu_cmd_addr = 32'h400; agu_cmd_size = 2'b10;
    step;
    chk("rstmid_req_valid", valid, 1);
    bus_cmd_ready = 1;
    step;
    bus_cmd_ready = 0;
    chk("rstmid_in_rsp", valid, 0);
    rst = 1;
    agu_cmd_enable = 0;
    step;
    rst = 0;
    bus_rsp_valid = 1; bus_rsp_rdata = 32'h7777_7777;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_valid", valid, 0);
    chk("rstmid_wback", wb_vld, 0);
    step;
    bus_rsp_valid = 0;
    chk("rstmid_wback2", wb_vld, 0);
    chk("rstmid_valid2", valid, 0);
    run(10);
    run(11);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
